battle_phase_ctrl: RTL
======================

// Module: battle_phase_ctrl
// PURPOSE
//  Top-level battle sequencer for one fight round loop: MENU -> ATTACK -> APPLY -> DODGE -> MENU.
//  Drives the Attack gauge block (start/reset), latches its damage, tracks enemy and player HP.
//  Runs a timed dodge window that counts player hits, and declares win or lose.
//  Sits between the input debouncer, the Attack block and the renderer (phase select).
// PARAMETERS
//  ENEMY_HP_INIT  100   enemy HP loaded at reset (8-bit)
//  PLAYER_HP_INIT 20    player HP loaded at reset (8-bit)
//  DODGE_LEN      1000  dodge window length in clk cycles (16-bit counter, 1..65535)
//  HIT_DMG        4     HP removed from player per accepted hit
//  INVULN_LEN     50    post-hit invulnerability cycles (used only with BPC_INVULN_EN)
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  confirm     in   1  single-cycle button pulse; leaves MENU
//  atk_pass    in   1  Attack block done flag (level)
//  atk_damage  in   8  Attack block damage result, valid while atk_pass=1
//  hit         in   1  single-cycle player/bullet collision pulse
//  atk_reset   out  1  reset strobe to Attack block
//  atk_start   out  1  enable to Attack block
//  dodge_active out 1  high for every DODGE cycle
//  enemy_hp    out  8  current enemy HP
//  player_hp   out  8  current player HP
//  phase       out  3  state code for renderer (encoding below)
//  win         out  1  sticky, enemy HP reached 0
//  lose        out  1  sticky, player HP reached 0
// BEHAVIOUR
//  - Reset: state=MENU, enemy_hp=ENEMY_HP_INIT, player_hp=PLAYER_HP_INIT, dodge counter=0;
//    atk_reset=0, atk_start=0, dodge_active=0, win=0, lose=0. Reset mid-operation aborts any phase.
//  - States/phase codes: MENU=0, ATK_INIT=1, ATK_RUN=2, APPLY=3, DODGE=4, WIN=5, LOSE=6.
//  - MENU: confirm=1 -> ATK_INIT next cycle; else hold. confirm ignored in all other states.
//  - ATK_INIT: atk_reset=1 for exactly one cycle; -> ATK_RUN.
//  - ATK_RUN: atk_start=1 (registered, asserted from first ATK_RUN cycle). When atk_pass=1
//    is sampled (ignore pass on first ATK_RUN cycle: Attack still clearing), latch atk_damage
//    into dmg_q, drop atk_start, -> APPLY. No timeout.
//  - APPLY (1 cycle): enemy_hp <= (enemy_hp > dmg_q) ? enemy_hp - dmg_q : 0 (saturating, no wrap).
//    Result 0 -> WIN; else -> DODGE with counter loaded to DODGE_LEN-1. dmg_q=0 is legal.
//  - DODGE: dodge_active=1; counter decrements per cycle. hit=1 -> player_hp saturating
//    subtract HIT_DMG. player_hp reaching 0 -> LOSE next cycle (priority over window end).
//    Hit on final cycle is still applied. Counter==0 and player alive -> MENU.
//  - hit outside DODGE ignored; atk_pass outside ATK_RUN ignored.
//  - WIN/LOSE: terminal, win/lose held 1, all strobes 0, until reset.
//  - Outputs are registers; phase reflects current state; HP update visible cycle after event.
// CONFIGURATION
//  BPC_INVULN_EN defined: after an accepted hit, further hits are ignored for INVULN_LEN
//    cycles (separate counter, cleared on entry to DODGE and on reset).
//  BPC_INVULN_EN undefined: every hit pulse in DODGE is accepted; no invuln counter built.
// TESTING
//  1 reset, confirm, Attack returns pass with damage=20 -> atk_reset pulse 1 cycle,
//    atk_start high, enemy_hp 100->80, DODGE entered, dodge_active for exactly DODGE_LEN cycles, phase back to 0.
//  2 enemy_hp=15, damage=20 -> enemy_hp saturates to 0, win=1, phase=5; further confirm ignored.
//  3 PLAYER_HP_INIT=6, two hits in DODGE -> player_hp 6->2->0, lose=1, phase=6, remaining window skipped.
//  4 hit on last DODGE cycle with player_hp=20 -> player_hp=16 and return to MENU; hit in MENU -> no change.
//  5 reset asserted during ATK_RUN and DODGE -> all outputs to reset values next cycle, phase=0.
//  6 BPC_INVULN_EN, INVULN_LEN=50: hits at t=0,10,60 -> only t=0 and t=60 accepted (20->16->12);
//    without macro all three accepted (20->8).

Source files
------------

// File: rtl/battle_phase_ctrl_if.sv
// Signal bundle between the battle sequencer, the input/Attack blocks and the renderer.
// master drives the button/Attack/collision inputs; slave is the sequencer.
interface battle_phase_ctrl_if;
  logic       confirm;
  logic       atk_pass;
  logic [7:0] atk_damage;
  logic       hit;
  logic       atk_reset;
  logic       atk_start;
  logic       dodge_active;
  logic [7:0] enemy_hp;
  logic [7:0] player_hp;
  logic [2:0] phase;
  logic       win;
  logic       lose;

  modport master (
    output confirm, atk_pass, atk_damage, hit,
    input  atk_reset, atk_start, dodge_active, enemy_hp, player_hp, phase, win, lose
  );

  modport slave (
    input  confirm, atk_pass, atk_damage, hit,
    output atk_reset, atk_start, dodge_active, enemy_hp, player_hp, phase, win, lose
  );
endinterface

// File: rtl/battle_phase_ctrl.sv
// Battle round sequencer: MENU -> ATTACK -> APPLY -> DODGE -> MENU, with sticky win/lose.
// Optional build macro BPC_INVULN_EN adds a post-hit invulnerability window.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   MENU     | idle, waiting for confirm
//   ATK_INIT | one-cycle atk_reset strobe to the Attack block
//   ATK_RUN  | atk_start held, waiting for atk_pass (first cycle ignored)
//   APPLY    | saturating enemy_hp -= dmg_q, pick WIN or DODGE
//   DODGE    | timed window, hits reduce player_hp
//   WIN      | terminal, enemy defeated
//   LOSE     | terminal, player defeated
module battle_phase_ctrl #(
  parameter int ENEMY_HP_INIT  = 100,
  parameter int PLAYER_HP_INIT = 20,
  parameter int DODGE_LEN      = 1000,
  parameter int HIT_DMG        = 4,
  parameter int INVULN_LEN     = 50
) (
  input logic               clk,
  input logic               reset,
  battle_phase_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_MENU     = 3'd0,
    S_ATK_INIT = 3'd1,
    S_ATK_RUN  = 3'd2,
    S_APPLY    = 3'd3,
    S_DODGE    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  localparam logic [7:0]  ENEMY_HP_RST  = 8'(ENEMY_HP_INIT);
  localparam logic [7:0]  PLAYER_HP_RST = 8'(PLAYER_HP_INIT);
  localparam logic [7:0]  HIT_DMG_B     = 8'(HIT_DMG);
  localparam logic [15:0] DODGE_LOAD    = 16'(DODGE_LEN - 1);

  state_t      state;
  logic [7:0]  dmg_q;
  logic [7:0]  enemy_hp_q;
  logic [7:0]  player_hp_q;
  logic [15:0] dodge_cnt;
  logic        atk_first;
  logic        atk_reset_q;
  logic        atk_start_q;
  logic        dodge_active_q;
  logic        win_q;
  logic        lose_q;

  logic        hit_ok;
  logic [7:0]  enemy_hp_next;
  logic [7:0]  player_hp_hit;

`ifdef BPC_INVULN_EN
  localparam logic [15:0] INVULN_LOAD = 16'(INVULN_LEN);
  logic [15:0] invuln_cnt;

  assign hit_ok = bus.hit && (invuln_cnt == 16'd0);
`else
  // Parameter kept so both builds share one instantiation signature.
  localparam int unused_invuln_len = INVULN_LEN;

  assign hit_ok = bus.hit;
`endif

  always_comb begin
    enemy_hp_next = 8'd0;
    if (enemy_hp_q > dmg_q) enemy_hp_next = enemy_hp_q - dmg_q;
    player_hp_hit = 8'd0;
    if (player_hp_q > HIT_DMG_B) player_hp_hit = player_hp_q - HIT_DMG_B;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_MENU;
      dmg_q          <= 8'd0;
      enemy_hp_q     <= ENEMY_HP_RST;
      player_hp_q    <= PLAYER_HP_RST;
      dodge_cnt      <= 16'd0;
      atk_first      <= 1'b0;
      atk_reset_q    <= 1'b0;
      atk_start_q    <= 1'b0;
      dodge_active_q <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
    end else begin
      case (state)
        S_MENU: begin
          if (bus.confirm) begin
            state       <= S_ATK_INIT;
            atk_reset_q <= 1'b1;
          end
        end
        S_ATK_INIT: begin
          state       <= S_ATK_RUN;
          atk_reset_q <= 1'b0;
          atk_start_q <= 1'b1;
          atk_first   <= 1'b1;
        end
        S_ATK_RUN: begin
          // Pass seen in the first cycle may be stale from the previous round.
          atk_first <= 1'b0;
          if (!atk_first && bus.atk_pass) begin
            dmg_q       <= bus.atk_damage;
            atk_start_q <= 1'b0;
            state       <= S_APPLY;
          end
        end
        S_APPLY: begin
          enemy_hp_q <= enemy_hp_next;
          if (enemy_hp_next == 8'd0) begin
            state <= S_WIN;
            win_q <= 1'b1;
          end else begin
            state          <= S_DODGE;
            dodge_cnt      <= DODGE_LOAD;
            dodge_active_q <= 1'b1;
          end
        end
        S_DODGE: begin
          if (hit_ok) player_hp_q <= player_hp_hit;
          if (hit_ok && (player_hp_hit == 8'd0)) begin
            state          <= S_LOSE;
            lose_q         <= 1'b1;
            dodge_active_q <= 1'b0;
          end else if (dodge_cnt == 16'd0) begin
            state          <= S_MENU;
            dodge_active_q <= 1'b0;
          end else begin
            dodge_cnt <= dodge_cnt - 16'd1;
          end
        end
        S_WIN, S_LOSE: begin
          state <= state;
        end
        default: begin
          state <= S_MENU;
        end
      endcase
    end
  end

`ifdef BPC_INVULN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      invuln_cnt <= 16'd0;
    end else if (state == S_APPLY) begin
      invuln_cnt <= 16'd0;
    end else if (state == S_DODGE && hit_ok) begin
      invuln_cnt <= INVULN_LOAD;
    end else if (invuln_cnt != 16'd0) begin
      invuln_cnt <= invuln_cnt - 16'd1;
    end
  end
`endif

  assign bus.atk_reset    = atk_reset_q;
  assign bus.atk_start    = atk_start_q;
  assign bus.dodge_active = dodge_active_q;
  assign bus.enemy_hp     = enemy_hp_q;
  assign bus.player_hp    = player_hp_q;
  assign bus.phase        = state;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;

endmodule
